// File: rtl/output_unit_controller_if.sv
// Output-unit port bundle: crossbar/SA side in, downstream link and credit status out.
// Latency: none (wires only).
// Backpressure: none on the link; credit status is the only flow control carried here.
interface output_unit_controller_if #(
    parameter int FLIT_WIDTH = 36,
    parameter int CNT_WIDTH  = 3
);
    logic                  st_valid;
    logic [FLIT_WIDTH-1:0] st_data;
    logic                  credit_decre;
    logic                  credit_return;
    logic                  credit_avail;
    logic                  link_valid;
    logic [FLIT_WIDTH-1:0] link_data;
    logic [CNT_WIDTH-1:0]  credit_count;
    logic                  err_overflow;
    logic                  err_underflow;

    // Crossbar / switch allocator / downstream credit source side
    modport master (
        output st_valid, st_data, credit_decre, credit_return,
        input  credit_avail, link_valid, link_data, credit_count,
        input  err_overflow, err_underflow
    );

    // Output unit controller side
    modport slave (
        input  st_valid, st_data, credit_decre, credit_return,
        output credit_avail, link_valid, link_data, credit_count,
        output err_overflow, err_underflow
    );
endinterface

// File: rtl/output_unit_controller.sv
// Output unit: downstream credit counter, credit-available flag and link register.
// Latency: st_valid -> link_valid 1 cycle; credit update visible in credit_avail 1 cycle after the edge.
// Backpressure: none on the link; credits guarantee downstream FIFO space, credit_avail gates SA.
module output_unit_controller #(
    parameter int BUFFER_DEPTH = 4,
    parameter int FLIT_WIDTH   = 36,
    parameter int CNT_WIDTH    = 3
) (
    input  logic clk,
    input  logic rst,
    output_unit_controller_if.slave ou
);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(BUFFER_DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  cnt_q,  cnt_d;
    logic                  ovf_q,  ovf_d;
    logic                  unf_q,  unf_d;
    logic                  link_valid_q, link_valid_d;
    logic [FLIT_WIDTH-1:0] link_data_q,  link_data_d;

    // Credit counter next state: saturates at 0 and BUFFER_DEPTH, flags the attempt to pass either bound.
    // Simultaneous decrement and return cancel, so no error is possible in that case.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        case ({ou.credit_decre, ou.credit_return})
            2'b10: begin
                if (cnt_q == '0) unf_d = 1'b1;
                else             cnt_d = cnt_q - ONE_C;
            end
            2'b01: begin
                if (cnt_q == DEPTH_C) ovf_d = 1'b1;
                else                  cnt_d = cnt_q + ONE_C;
            end
            default: cnt_d = cnt_q;
        endcase
    end

    // Link next state: forward the crossbar flit, zero the data bus on idle cycles.
    always_comb begin
        link_valid_d = ou.st_valid;
        link_data_d  = ou.st_valid ? ou.st_data : '0;
    end

    // State registers; reset drops any flit held on the link and restores full credit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= DEPTH_C;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            link_valid_q <= 1'b0;
            link_data_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            link_valid_q <= link_valid_d;
            link_data_q  <= link_data_d;
        end
    end

    // Outputs come straight from registers; credit_avail only looks at the registered count.
    assign ou.credit_avail  = (cnt_q != '0);
    assign ou.credit_count  = cnt_q;
    assign ou.link_valid    = link_valid_q;
    assign ou.link_data     = link_data_q;
    assign ou.err_overflow  = ovf_q;
    assign ou.err_underflow = unf_q;
endmodule

// File: tb/tb_output_unit_controller.sv
// Directed bench for output_unit_controller: credit counting, saturation flags, link timing, async reset.
// Latency: checks are taken 1 time unit after each rising clk edge.
// Backpressure: not applicable; stimulus is driven freely every cycle.
module tb_output_unit_controller;
    localparam int BUFFER_DEPTH = 4;
    localparam int FLIT_WIDTH   = 36;
    localparam int CNT_WIDTH    = 3;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    output_unit_controller_if #(.FLIT_WIDTH(FLIT_WIDTH), .CNT_WIDTH(CNT_WIDTH)) ou ();

    output_unit_controller #(
        .BUFFER_DEPTH(BUFFER_DEPTH),
        .FLIT_WIDTH  (FLIT_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ou (ou.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dec, input logic ret);
        ou.credit_decre  = dec;
        ou.credit_return = ret;
    endtask

    logic [FLIT_WIDTH-1:0] d0;
    logic [FLIT_WIDTH-1:0] d1;
    logic [FLIT_WIDTH-1:0] fa;
    logic [2:0]            exp_cnt [4];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        fa = 36'hA_1234_00FF;
        d0 = 36'h5_0F0F_1357;
        d1 = 36'h3_BEEF_CAFE;
        exp_cnt[0] = 3'd3; exp_cnt[1] = 3'd2; exp_cnt[2] = 3'd1; exp_cnt[3] = 3'd0;

        ou.st_valid = 1'b0;
        ou.st_data  = '0;
        drive(1'b0, 1'b0);
        rst = 1'b1;
        #12;
        rst = 1'b0;
        step();

        // Reset / idle state
        chk("rst_cnt",   64'(ou.credit_count),  64'd4);
        chk("rst_avail", 64'(ou.credit_avail),  64'd1);
        chk("rst_lvld",  64'(ou.link_valid),    64'd0);
        chk("rst_ldat",  64'(ou.link_data),     64'd0);
        chk("rst_ovf",   64'(ou.err_overflow),  64'd0);
        chk("rst_unf",   64'(ou.err_underflow), 64'd0);

        // Four decrements down to zero
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0);
            step();
            chk($sformatf("dec_cnt%0d", i), 64'(ou.credit_count), 64'(exp_cnt[i]));
            chk($sformatf("dec_avail%0d", i), 64'(ou.credit_avail), (i == 3) ? 64'd0 : 64'd1);
        end
        chk("dec_unf_pre", 64'(ou.err_underflow), 64'd0);
        // Fifth decrement at zero: saturate and flag
        step();
        chk("unf_cnt", 64'(ou.credit_count),  64'd0);
        chk("unf_flag", 64'(ou.err_underflow), 64'd1);

        // Decrement and return together at zero: hold, no new flags
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1);
            step();
            chk($sformatf("both_cnt%0d", i), 64'(ou.credit_count), 64'd0);
            chk($sformatf("both_ovf%0d", i), 64'(ou.err_overflow), 64'd0);
        end
        drive(1'b0, 1'b1);
        step();
        chk("ret_cnt1",   64'(ou.credit_count), 64'd1);
        chk("ret_avail1", 64'(ou.credit_avail), 64'd1);
        chk("unf_sticky", 64'(ou.err_underflow), 64'd1);

        // Return up to full, then one extra
        step(); step(); step();
        chk("ret_full",  64'(ou.credit_count), 64'd4);
        chk("ovf_pre",   64'(ou.err_overflow), 64'd0);
        step();
        chk("ovf_cnt",   64'(ou.credit_count), 64'd4);
        chk("ovf_flag",  64'(ou.err_overflow), 64'd1);
        drive(1'b1, 1'b0);
        step();
        chk("norm_cnt3", 64'(ou.credit_count), 64'd3);
        drive(1'b0, 1'b1);
        step();
        chk("norm_cnt4", 64'(ou.credit_count), 64'd4);
        drive(1'b0, 1'b0);
        step();
        chk("ovf_sticky", 64'(ou.err_overflow), 64'd1);

        // Single flit, then idle with junk on the data bus
        ou.st_valid = 1'b1;
        ou.st_data  = fa;
        step();
        chk("fl_vld",  64'(ou.link_valid), 64'd1);
        chk("fl_dat",  64'(ou.link_data),  64'(fa));
        ou.st_valid = 1'b0;
        ou.st_data  = d1;
        step();
        chk("fl_vld0", 64'(ou.link_valid), 64'd0);
        chk("fl_dat0", 64'(ou.link_data),  64'd0);

        // Back-to-back flits
        ou.st_valid = 1'b1;
        ou.st_data  = d0;
        step();
        chk("b2b_vld0", 64'(ou.link_valid), 64'd1);
        chk("b2b_dat0", 64'(ou.link_data),  64'(d0));
        ou.st_data  = d1;
        step();
        chk("b2b_vld1", 64'(ou.link_valid), 64'd1);
        chk("b2b_dat1", 64'(ou.link_data),  64'(d1));
        ou.st_valid = 1'b0;
        ou.st_data  = '0;
        step();
        chk("b2b_end", 64'(ou.link_valid), 64'd0);

        // Bring count to 1 with a flit in the link register, then async reset mid-cycle
        drive(1'b1, 1'b0);
        step(); step();
        ou.st_valid = 1'b1;
        ou.st_data  = fa;
        step();
        drive(1'b0, 1'b0);
        ou.st_valid = 1'b0;
        chk("pre_cnt1", 64'(ou.credit_count), 64'd1);
        chk("pre_lvld", 64'(ou.link_valid),   64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt",   64'(ou.credit_count),  64'd4);
        chk("arst_avail", 64'(ou.credit_avail),  64'd1);
        chk("arst_lvld",  64'(ou.link_valid),    64'd0);
        chk("arst_ldat",  64'(ou.link_data),     64'd0);
        chk("arst_ovf",   64'(ou.err_overflow),  64'd0);
        chk("arst_unf",   64'(ou.err_underflow), 64'd0);
        #4;
        rst = 1'b0;
        step();
        chk("post_cnt", 64'(ou.credit_count), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/output_unit_controller.md
Name: output_unit_controller

Overview:
- Output-side counterpart of the router input unit. It owns the credit-based flow control for one output direction.
- Keeps the downstream buffer credit count and exports a credit-available flag to the input units' switch-allocation requests.
- Registers the flit leaving the crossbar and drives the link to the downstream node's input FIFO.
- Absorbs credit returns that the downstream input unit sends back.

Parameters:
- BUFFER_DEPTH, 4, depth of the downstream input FIFO; this is the initial credit count.
- FLIT_WIDTH, 36, flit width: [35:32] info, [31:16] address, [15:0] payload.
- CNT_WIDTH, 3, credit counter width; must hold BUFFER_DEPTH, i.e. ≥ clog2(BUFFER_DEPTH+1).

Ports:
- clk  input  1  system clock
- rst  input  1  system reset, asynchronous, active high
- st_valid  input  1  crossbar output for this direction carries a flit this cycle
- st_data  input  FLIT_WIDTH  crossbar output flit
- credit_decre  input  1  OR of the input units' credit-decrement bits for this direction; asserted on SA grant
- credit_return  input  1  credit pulse from the downstream input unit (one FIFO slot freed)
- credit_avail  output  1  at least one downstream credit remains
- link_valid  output  1  flit valid to downstream; drives its FIFO write enable
- link_data  output  FLIT_WIDTH  flit to downstream FIFO
- credit_count  output  CNT_WIDTH  current credit count (debug/verification)
- err_overflow  output  1  sticky: credit returned while the count was already BUFFER_DEPTH
- err_underflow  output  1  sticky: decrement while the count was 0

Behaviour:
Reset:
- Reset is asynchronous and active-high. It is applied on posedge rst, at any time, including mid-transfer.
- Reset values: credit_count = BUFFER_DEPTH, credit_avail = 1, link_valid = 0, link_data = 0, err_overflow = 0, err_underflow = 0.
- A flit in the link register at reset is dropped, not replayed.

Credit counter (register cnt):
- credit_decre=1, credit_return=0: cnt-1. If cnt==0, hold 0 and set err_underflow.
- credit_decre=0, credit_return=1: cnt+1. If cnt==BUFFER_DEPTH, hold BUFFER_DEPTH and set err_overflow.
- Both asserted in the same cycle: cnt unchanged. Neither error flag is set, even at 0 or BUFFER_DEPTH.
- Neither asserted: hold.
- The counter never wraps. Arithmetic is unsigned, CNT_WIDTH bits.

credit_avail:
- credit_avail = (cnt != 0), decoded combinationally from the registered cnt. It has no dependency on credit_decre or credit_return in the same cycle.
- A decrement taken at edge N is visible in credit_avail from cycle N+1.
- With cnt==1, a grant in cycle N drops credit_avail in N+1. This blocks a second request toward a full downstream FIFO.

Link register:
- On each clk edge: link_valid <= st_valid, link_data <= (st_valid ? st_data : 0).
- Latency st_valid → link_valid is exactly 1 cycle.
- One flit per cycle sustained; no backpressure on the link. Credits guarantee the downstream FIFO has space.
- link_valid is a single-cycle pulse per flit. Back-to-back flits give back-to-back pulses.

Error flags:
- err_overflow and err_underflow are sticky until reset.
- They do not alter link behaviour.

Consistency:
- credit_decre and st_valid are not required to coincide. The input unit asserts the decrement on grant, one cycle before its registered ST data arrives.
- This block does not check their pairing.

Test Plan:
- Reset, BUFFER_DEPTH=4, idle → credit_count=4, credit_avail=1, link_valid=0, link_data=0, both error flags 0.
- Four credit_decre pulses in cycles 1–4, no returns → credit_count 3,2,1,0; credit_avail=0 from cycle 5; a fifth decre leaves count 0 and sets err_underflow=1.
- From count 0, credit_decre and credit_return both asserted for 3 cycles → count stays 0, no error flag. Then a single return → count 1, credit_avail=1 next cycle.
- Count 4 plus credit_return → count stays 4, err_overflow=1, and it stays 1 through subsequent normal traffic until rst.
- st_valid=1 with st_data=36'hA_1234_00FF in cycle N, then 0 → link_valid=1 and link_data=36'hA_1234_00FF in cycle N+1 only; link_data=0 in N+2. Back-to-back flits D0,D1 in cycles N,N+1 → link_valid high for N+1 and N+2 carrying D0,D1.
- Async rst pulse mid-cycle at count=1 with link_valid=1 → immediately count=4, credit_avail=1, link_valid=0, without waiting for a clk edge.
